// File: rtl/pir_capture_ctrl_if.sv
// AXI4-Stream beat channel from pir_capture_ctrl toward the Zynq DMA.
interface pir_capture_ctrl_if;
  logic        tvalid;
  logic [15:0] tdata;
  logic        tlast;
  logic        tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/pir_capture_ctrl.sv
// PIR-triggered frame capture sequencer: aligns to frame_start, forwards whole frames as AXIS beats.
// Optional macro PIR_CAPTURE_DROP_CNT_EN builds the 16-bit saturating drop_count.
module pir_capture_ctrl #(
  parameter int unsigned FRAME_PIXELS     = 76800,
  parameter int unsigned FRAMES_PER_EVENT = 1,
  parameter int unsigned COOLDOWN_CYCLES  = 1000000,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                     M_AXIS_ACLK,
  input  logic                     M_AXIS_ARESET,
  input  logic                     enable,
  input  logic                     pir_motion,
  input  logic                     frame_start,
  input  logic [15:0]              pixel_data,
  input  logic                     pixel_valid,
  input  logic                     status_clr,
  pir_capture_ctrl_if.master       m_axis,
  output logic                     busy,
  output logic                     overflow,
  output logic                     short_frame,
  output logic [15:0]              drop_count
);

  localparam int unsigned PIX_W = $clog2(FRAME_PIXELS);
  localparam int unsigned FRM_W = $clog2(FRAMES_PER_EVENT + 1);
  localparam int unsigned CD_W  = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [FRM_W-1:0] NUM_FRAMES = FRM_W'(FRAMES_PER_EVENT);
  localparam logic [CD_W-1:0]  CD_LOAD    = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARMED    = 3'd1;
  localparam logic [2:0] S_CAPTURE  = 3'd2;
  localparam logic [2:0] S_FLUSH    = 3'd3;
  localparam logic [2:0] S_COOLDOWN = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CD_W-1:0]  timer_q, timer_d;
  logic             overflow_q, overflow_d;
  logic             short_q, short_d;

  // Each entry is {pixel, last}.
  logic [16:0]      mem_q [FIFO_DEPTH];
  logic [16:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  logic             push, push_last, short_set;
  logic [PIX_W-1:0] idx;
  logic             fifo_empty, fifo_full, pop, push_ok, drop;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
  assign pop        = !fifo_empty && m_axis.tready;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    frame_cnt_d = frame_cnt_q;
    timer_d     = timer_q;
    push        = 1'b0;
    push_last   = 1'b0;
    short_set   = 1'b0;
    idx         = pix_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (enable && pir_motion) begin
          state_d     = S_ARMED;
          frame_cnt_d = '0;
        end
      end
      S_ARMED: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (frame_start) begin
          state_d   = S_CAPTURE;
          pix_cnt_d = '0;
          if (pixel_valid) begin
            push      = 1'b1;
            pix_cnt_d = PIX_W'(1);
          end
        end
      end
      S_CAPTURE: begin
        // A mid-frame frame_start restarts the count; a same-cycle pixel becomes pixel 0.
        if (frame_start) begin
          short_set = 1'b1;
          idx       = '0;
        end
        pix_cnt_d = idx;
        if (pixel_valid) begin
          push = 1'b1;
          if (idx == LAST_PIX) begin
            push_last   = 1'b1;
            pix_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q + 1'b1;
            if ((frame_cnt_d == NUM_FRAMES) || !enable) state_d = S_FLUSH;
            else                                       state_d = S_ARMED;
          end else begin
            pix_cnt_d = idx + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (fifo_empty) begin
          state_d = S_COOLDOWN;
          timer_d = CD_LOAD;
        end
      end
      S_COOLDOWN: begin
        if (!enable || (timer_q == '0)) state_d = S_IDLE;
        else                            timer_d = timer_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push_ok = push && (!fifo_full || pop);
  assign drop    = push && fifo_full && !pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {pixel_data, push_last};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    // A dropped last pixel still terminates the frame via the newest buffered beat.
    if (drop && push_last) mem_d[wr_ptr_q - 1'b1][0] = 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    overflow_d = status_clr ? 1'b0 : overflow_q;
    short_d    = status_clr ? 1'b0 : short_q;
    if (drop)      overflow_d = 1'b1;
    if (short_set) short_d    = 1'b1;
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      frame_cnt_q <= '0;
      timer_q     <= '0;
      overflow_q  <= 1'b0;
      short_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      timer_q     <= timer_d;
      overflow_q  <= overflow_d;
      short_q     <= short_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      mem_q       <= mem_d;
    end
  end

`ifdef PIR_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Clear is applied first so a same-cycle drop still counts as 1.
  always_comb begin
    drop_cnt_d = status_clr ? '0 : drop_cnt_q;
    if (drop && (drop_cnt_d != '1)) drop_cnt_d = drop_cnt_d + 1'b1;
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) drop_cnt_q <= '0;
    else               drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : mem_q[rd_ptr_q][16:1];
  assign m_axis.tlast  = fifo_empty ? 1'b0 : mem_q[rd_ptr_q][0];
  assign busy          = (state_q != S_IDLE);
  assign overflow      = overflow_q;
  assign short_frame   = short_q;

endmodule

// File: tb/tb_pir_capture_ctrl.sv
// Directed self-checking bench for pir_capture_ctrl (8-pixel frames, 2 frames/event, 5-clock cooldown).
module tb_pir_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, pir, fs, pv, clr;
  logic [15:0] pd;
  logic        busy, overflow, short_frame;
  logic [15:0] drop_count;
  int          tests = 0;
  int          fails = 0;

`ifdef PIR_CAPTURE_DROP_CNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd4;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  pir_capture_ctrl_if axis ();

  pir_capture_ctrl #(
    .FRAME_PIXELS(8),
    .FRAMES_PER_EVENT(2),
    .COOLDOWN_CYCLES(5),
    .FIFO_DEPTH(4)
  ) dut (
    .M_AXIS_ACLK(clk),
    .M_AXIS_ARESET(rst),
    .enable(enable),
    .pir_motion(pir),
    .frame_start(fs),
    .pixel_data(pd),
    .pixel_valid(pv),
    .status_clr(clr),
    .m_axis(axis.master),
    .busy(busy),
    .overflow(overflow),
    .short_frame(short_frame),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends n pixels base..base+n-1 with frame_start on the first; TREADY assumed high.
  task automatic frame(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fs = (i == 0);
      pv = 1'b1;
      pd = base + 16'(i);
      tick();
      chk("beat_valid", {31'd0, axis.tvalid}, 32'd1);
      chk("beat_data", {16'd0, axis.tdata}, {16'd0, base + 16'(i)});
      chk("beat_last", {31'd0, axis.tlast}, {31'd0, (i == 7)});
    end
    fs = 1'b0;
    pv = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pir = 1'b0; fs = 1'b0; pv = 1'b0; clr = 1'b0;
    pd = '0; axis.tready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    chk("rst_tdata", {16'd0, axis.tdata}, 32'd0);
    chk("rst_tlast", {31'd0, axis.tlast}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_short", {31'd0, short_frame}, 32'd0);
    chk("rst_drops", {16'd0, drop_count}, 32'd0);

    // Basic event with alignment: pixels before frame_start are ignored.
    enable = 1'b1; pir = 1'b1;
    tick();
    pir = 1'b0;
    chk("armed_busy", {31'd0, busy}, 32'd1);
    pv = 1'b1; pd = 16'hAAAA;
    tick();
    chk("align_ignore0", {31'd0, axis.tvalid}, 32'd0);
    tick();
    chk("align_ignore1", {31'd0, axis.tvalid}, 32'd0);
    frame(16'h0000, 8);
    tick();
    chk("gap_tvalid", {31'd0, axis.tvalid}, 32'd0);
    frame(16'h0000, 8);
    tick();
    chk("flush_drained", {31'd0, axis.tvalid}, 32'd0);
    repeat (5) tick();
    chk("cooldown_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("idle_after_cd", {31'd0, busy}, 32'd0);

    // pir held high through cooldown re-arms only after IDLE.
    pir = 1'b1;
    tick();
    chk("rearm_busy", {31'd0, busy}, 32'd1);
    frame(16'h0020, 8);
    frame(16'h0028, 8);
    repeat (6) tick();
    chk("cd_hold_pir", {31'd0, busy}, 32'd1);
    tick();
    chk("cd_idle_pir", {31'd0, busy}, 32'd0);
    tick();
    chk("pir_rearm", {31'd0, busy}, 32'd1);
    enable = 1'b0;
    tick();
    chk("armed_disable", {31'd0, busy}, 32'd0);
    pir = 1'b0; enable = 1'b1;
    tick();
    chk("stay_idle", {31'd0, busy}, 32'd0);

    // Backpressure: 4 beats buffered, 4 dropped, last flag folded onto beat 4.
    pir = 1'b1;
    tick();
    pir = 1'b0;
    axis.tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fs = (i == 0); pv = 1'b1; pd = 16'h0100 + 16'(i);
      tick();
      chk("bp_hold_data", {16'd0, axis.tdata}, 32'h0100);
    end
    fs = 1'b0; pv = 1'b0;
    chk("bp_tvalid", {31'd0, axis.tvalid}, 32'd1);
    chk("bp_head_last", {31'd0, axis.tlast}, 32'd0);
    chk("bp_overflow", {31'd0, overflow}, 32'd1);
    chk("bp_drops", {16'd0, drop_count}, {16'd0, EXP_DROPS});
    axis.tready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("bp_data", {16'd0, axis.tdata}, 32'h0100 + 32'(i));
      chk("bp_last", {31'd0, axis.tlast}, {31'd0, (i == 3)});
    end
    tick();
    chk("bp_drained", {31'd0, axis.tvalid}, 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_overflow", {31'd0, overflow}, 32'd0);
    chk("clr_drops", {16'd0, drop_count}, 32'd0);
    chk("no_short_yet", {31'd0, short_frame}, 32'd0);

    // Short frame: second frame of the same event restarts after 5 pixels.
    frame(16'h0200, 5);
    chk("short_clear", {31'd0, short_frame}, 32'd0);
    frame(16'h0300, 8);
    chk("short_set", {31'd0, short_frame}, 32'd1);
    repeat (8) tick();
    chk("short_evt_done", {31'd0, busy}, 32'd0);

    // Reset mid-capture with 3 beats buffered.
    pir = 1'b1;
    tick();
    pir = 1'b0;
    axis.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fs = (i == 0); pv = 1'b1; pd = 16'h0400 + 16'(i);
      tick();
    end
    fs = 1'b0; pv = 1'b0;
    chk("pre_rst_valid", {31'd0, axis.tvalid}, 32'd1);
    chk("pre_rst_data", {16'd0, axis.tdata}, 32'h0400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    chk("mid_rst_tdata", {16'd0, axis.tdata}, 32'd0);
    chk("mid_rst_tlast", {31'd0, axis.tlast}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_short", {31'd0, short_frame}, 32'd0);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    chk("mid_rst_drops", {16'd0, drop_count}, 32'd0);
    axis.tready = 1'b1;
    fs = 1'b1; pv = 1'b1; pd = 16'h0500;
    tick();
    fs = 1'b0; pv = 1'b0;
    chk("post_rst_idle", {31'd0, axis.tvalid}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
